// File: rtl/uart_arb_pkg.sv
// rtl/uart_arb_pkg.sv - shared state encoding and constants for the UART transmit arbiter
package uart_arb_pkg;

   localparam int MAX_REQ   = 8;
   localparam int IDX_W     = $clog2(MAX_REQ);
   localparam int HDR_TAG_W = 4;
   localparam int HDR_IDX_W = 4;
   localparam int HDR_W     = HDR_TAG_W + HDR_IDX_W;

   // One-hot state encoding; HDR is only reachable when the header feature is built
   typedef enum logic [3:0] {
      IDLE = 4'b0001,
      LOAD = 4'b0010,
      WAIT = 4'b0100,
      HDR  = 4'b1000
   } arb_state_e;

   // Frame header: tag in the upper nibble, requester index in the lower nibble
   function automatic logic [HDR_W-1:0] hdr_byte(input logic [HDR_TAG_W-1:0] tag,
                                                 input logic [IDX_W-1:0]     idx);
      return {tag, {(HDR_IDX_W-IDX_W){1'b0}}, idx};
   endfunction

endpackage

// File: rtl/uart_tx_arb_if.sv
// rtl/uart_tx_arb_if.sv - requester and UART transmitter signal bundle for the arbiter
interface uart_tx_arb_if #(
   parameter int NUM_REQ = 4
) ();

   logic [NUM_REQ*8-1:0] req_data;
   logic [NUM_REQ-1:0]   req_vld;
   logic [NUM_REQ-1:0]   req_last;
   logic [NUM_REQ-1:0]   req_ready;
   logic [NUM_REQ-1:0]   grant;
   logic                 busy;
   logic [7:0]           tx_data;
   logic                 tx_data_vld;
   logic                 uart_ready;

   // Arbiter side
   modport master (
      input  req_data, req_vld, req_last, uart_ready,
      output req_ready, grant, busy, tx_data, tx_data_vld
   );

   // Requester and UART side
   modport slave (
      output req_data, req_vld, req_last, uart_ready,
      input  req_ready, grant, busy, tx_data, tx_data_vld
   );

endinterface

// File: rtl/uart_tx_arb_rr_pick.sv
// rtl/uart_tx_arb_rr_pick.sv - rotating-priority pick of the next requester after last_i
module rr_pick
   import uart_arb_pkg::*;
#(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0] vld_i,
   input  logic [IDX_W-1:0]   last_i,
   output logic [NUM_REQ-1:0] grant_next_o,
   output logic               any_o
);

   // Walk slots last_i+1, last_i+2, ... with wrap; the first valid one wins
   always_comb begin
      int slot;
      slot         = 0;
      grant_next_o = '0;
      any_o        = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         slot = int'(last_i) + k;
         if (slot >= NUM_REQ) begin
            slot = slot - NUM_REQ;
         end
         for (int j = 0; j < NUM_REQ; j++) begin
            if (!any_o && (j == slot) && vld_i[j]) begin
               grant_next_o[j] = 1'b1;
               any_o           = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/uart_tx_arb.sv
// rtl/uart_tx_arb.sv - round-robin frame-locked arbiter sharing one UART transmitter (optional header byte: UART_ARB_HDR_EN)
module uart_tx_arb
   import uart_arb_pkg::*;
#(
   parameter int         NUM_REQ = 4,
   parameter logic [3:0] HDR_TAG = 4'hA
) (
   input  logic          clk,
   input  logic          rst,
   uart_tx_arb_if.master bus
);

   arb_state_e         state_q, state_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic [IDX_W-1:0]   gidx_q, gidx_d;
   logic [IDX_W-1:0]   last_grant_q, last_grant_d;
   logic               last_r_q, last_r_d;
   logic [7:0]         tx_data_q, tx_data_d;
   logic               tx_vld_q, tx_vld_d;

   logic [NUM_REQ-1:0] pick_grant;
   logic               pick_any;
   logic [IDX_W-1:0]   pick_idx;
   logic [NUM_REQ-1:0] req_ready;
   logic [7:0]         sel_data;
   logic               sel_vld;
   logic               sel_last;

`ifndef UART_ARB_HDR_EN
   logic [3:0] unused_hdr_tag;
   assign unused_hdr_tag = HDR_TAG;
`endif

   rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
      .vld_i        (bus.req_vld),
      .last_i       (last_grant_q),
      .grant_next_o (pick_grant),
      .any_o        (pick_any)
   );

   // Index of the freshly picked requester, kept for last_grant and the header byte
   always_comb begin
      pick_idx = '0;
      for (int j = 0; j < NUM_REQ; j++) begin
         if (pick_grant[j]) begin
            pick_idx = IDX_W'(j);
         end
      end
   end

   // Steer the granted requester's byte, valid and last flag
   always_comb begin
      sel_data = '0;
      sel_vld  = 1'b0;
      sel_last = 1'b0;
      for (int j = 0; j < NUM_REQ; j++) begin
         if (grant_q[j]) begin
            sel_data = bus.req_data[j*8 +: 8];
            sel_vld  = bus.req_vld[j];
            sel_last = bus.req_last[j];
         end
      end
   end

   // Next-state and handshake decode; the grant is held until the last byte clears the UART
   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      gidx_d       = gidx_q;
      last_grant_d = last_grant_q;
      last_r_d     = last_r_q;
      tx_data_d    = tx_data_q;
      tx_vld_d     = 1'b0;
      req_ready    = '0;
      case (state_q)
         IDLE: begin
            if (pick_any) begin
               grant_d = pick_grant;
               gidx_d  = pick_idx;
`ifdef UART_ARB_HDR_EN
               state_d = HDR;
`else
               state_d = LOAD;
`endif
            end
         end
`ifdef UART_ARB_HDR_EN
         HDR: begin
            if (bus.uart_ready) begin
               tx_data_d = hdr_byte(HDR_TAG, gidx_q);
               tx_vld_d  = 1'b1;
               last_r_d  = 1'b0;
               state_d   = WAIT;
            end
         end
`endif
         LOAD: begin
            req_ready = grant_q & {NUM_REQ{bus.uart_ready}};
            if (bus.uart_ready && sel_vld) begin
               tx_data_d = sel_data;
               tx_vld_d  = 1'b1;
               last_r_d  = sel_last;
               state_d   = WAIT;
            end
         end
         WAIT: begin
            // uart_ready is still high during the strobe cycle, so ignore it then
            if (bus.uart_ready && !tx_vld_q) begin
               if (last_r_q) begin
                  grant_d      = '0;
                  last_grant_d = gidx_q;
                  state_d      = IDLE;
               end else begin
                  state_d = LOAD;
               end
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         grant_q      <= '0;
         gidx_q       <= '0;
         last_grant_q <= IDX_W'(NUM_REQ-1);
         last_r_q     <= 1'b0;
         tx_data_q    <= 8'h00;
         tx_vld_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         gidx_q       <= gidx_d;
         last_grant_q <= last_grant_d;
         last_r_q     <= last_r_d;
         tx_data_q    <= tx_data_d;
         tx_vld_q     <= tx_vld_d;
      end
   end

   assign bus.req_ready   = req_ready;
   assign bus.grant       = grant_q;
   assign bus.busy        = (state_q != IDLE);
   assign bus.tx_data     = tx_data_q;
   assign bus.tx_data_vld = tx_vld_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb/tb_uart_tx_arb.sv - randomized self-checking bench for uart_tx_arb with a frame-level round-robin model
module tb_uart_tx_arb;

   localparam int         N        = 4;
   localparam int         BIT_CYC  = 4;
   localparam int         BYTE_CYC = 10 * BIT_CYC;
   localparam logic [3:0] TAG      = 4'hA;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   uart_tx_arb_if #(.NUM_REQ(N)) bus ();

   uart_tx_arb #(.NUM_REQ(N), .HDR_TAG(TAG)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Per-requester byte stores: {last, data}
   logic [8:0]  src_mem [N][256];
   int          src_rd   [N] = '{default: 0};
   int          src_wr   [N] = '{default: 0};
   int          sched_rd [N] = '{default: 0};
   bit          acc_flag [N] = '{default: 0};
   int          acc_cnt  [N] = '{default: 0};
   bit          stall    [N] = '{default: 0};
   logic [11:0] exp_q [$];
   logic [11:0] mon_e;
   int          model_last   = N - 1;
   int          strobe_cnt   = 0;
   int          uart_handled = 0;
   int          uart_cnt     = 0;
   bit          prev_vld     = 0;
   bit          hdr_seen     = 0;

   task automatic add_byte(input int r, input logic [7:0] b, input bit last);
      src_mem[r][src_wr[r]] = {last, b};
      src_wr[r]++;
   endtask

   // Whole frames leave in round-robin order among requesters that have frames pending
   task automatic schedule();
      int         r;
      int         c;
      bit         found;
      logic [8:0] e;
      forever begin
         found = 0;
         r     = 0;
         for (int k = 1; k <= N; k++) begin
            c = (model_last + k) % N;
            if (!found && sched_rd[c] != src_wr[c]) begin
               found = 1;
               r     = c;
            end
         end
         if (!found) break;
`ifdef UART_ARB_HDR_EN
         exp_q.push_back({4'(r), TAG, 4'(r)});
`endif
         do begin
            e = src_mem[r][sched_rd[r]];
            sched_rd[r]++;
            exp_q.push_back({4'(r), e[7:0]});
         end while (!e[8]);
         model_last = r;
      end
   endtask

   function automatic int pending();
      int p;
      p = 0;
      for (int i = 0; i < N; i++) p += src_wr[i] - src_rd[i];
      return p;
   endfunction

   task automatic wait_drain(input string tag);
      int n;
      bit done;
      n    = 0;
      done = 0;
      while (!done && n < 5000) begin
         @(negedge clk);
         n++;
         done = (exp_q.size() == 0) && (bus.grant == '0) && !bus.busy && (pending() == 0);
      end
      chk(tag, 32'(done), 1);
   endtask

   task automatic wait_strobe(input int base, input string tag);
      int n;
      n = 0;
      while (strobe_cnt == base && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 32'(strobe_cnt != base), 1);
   endtask

   // Requester drivers: present the head byte, advance after an observed transfer
   initial begin
      bus.req_vld  = '0;
      bus.req_data = '0;
      bus.req_last = '0;
      forever begin
         @(posedge clk);
         #1;
         for (int i = 0; i < N; i++) begin
            if (acc_flag[i]) begin
               src_rd[i]++;
               acc_flag[i] = 0;
            end
            bus.req_vld[i]         = (src_rd[i] != src_wr[i]) && !stall[i];
            bus.req_data[i*8 +: 8] = src_mem[i][src_rd[i]][7:0];
            bus.req_last[i]        = src_mem[i][src_rd[i]][8];
         end
      end
   end

   // UART model: drops ready the cycle after it samples a strobe, for one byte time
   initial begin
      bus.uart_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (!rst) begin
            bus.uart_ready = 1'b1;
            uart_cnt       = 0;
            uart_handled   = strobe_cnt;
         end else if (uart_handled != strobe_cnt) begin
            uart_handled   = strobe_cnt;
            bus.uart_ready = 1'b0;
            uart_cnt       = BYTE_CYC;
         end else if (uart_cnt > 0) begin
            uart_cnt--;
            if (uart_cnt == 0) bus.uart_ready = 1'b1;
         end
      end
   end

   // Monitor: serial stream against the model, frame lock, transfer bookkeeping
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            chk("lock", 32'(bus.req_ready & ~bus.grant), 0);
            if (bus.grant == '0) hdr_seen = 0;
            if (bus.tx_data_vld) begin
               chk("strobe_ready", 32'(bus.uart_ready), 1);
               chk("strobe_single", 32'(prev_vld), 0);
               chk("exp_avail", 32'(exp_q.size() != 0), 1);
               if (exp_q.size() != 0) begin
                  mon_e = exp_q.pop_front();
                  chk("tx_byte", 32'(bus.tx_data), 32'(mon_e[7:0]));
                  chk("owner", 32'(bus.grant), 32'(1) << mon_e[11:8]);
               end
               strobe_cnt++;
               hdr_seen = 1;
            end
            for (int i = 0; i < N; i++) begin
               if (bus.req_vld[i] && bus.req_ready[i]) begin
                  acc_flag[i] = 1;
                  acc_cnt[i]++;
`ifdef UART_ARB_HDR_EN
                  chk("hdr_first", 32'(hdr_seen), 1);
`endif
               end
            end
            prev_vld = bus.tx_data_vld;
         end else begin
            prev_vld = 0;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int a0;
      int a2;
      int a3;
      int s;
      int n;
      int nf;
      int len;

      // Two requesters pending at reset release, each with two 1-byte frames
      add_byte(0, 8'hA0, 1'b1);
      add_byte(2, 8'hA2, 1'b1);
      add_byte(0, 8'hA0, 1'b1);
      add_byte(2, 8'hA2, 1'b1);
      schedule();
      repeat (3) @(negedge clk);
      chk("rst_grant", 32'(bus.grant), 0);
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_tx_data", 32'(bus.tx_data), 0);
      chk("rst_tx_vld", 32'(bus.tx_data_vld), 0);
      chk("rst_req_ready", 32'(bus.req_ready), 0);
      rst = 1'b1;
      wait_drain("p2_drain");

      // Three-byte frame from requester 0
      a0 = acc_cnt[0];
      add_byte(0, 8'h11, 1'b0);
      add_byte(0, 8'h22, 1'b0);
      add_byte(0, 8'h33, 1'b1);
      schedule();
      wait_drain("p1_drain");
      chk("p1_accepts", 32'(acc_cnt[0] - a0), 3);

      // Requester 3 arrives while requester 1's frame is on the line
      add_byte(1, 8'h01, 1'b0);
      add_byte(1, 8'h02, 1'b1);
      schedule();
      s = strobe_cnt;
      wait_strobe(s, "p3_first");
      a3 = acc_cnt[3];
      add_byte(3, 8'h03, 1'b1);
      schedule();
      s = strobe_cnt;
      wait_strobe(s, "p3_second");
      chk("p3_no_acc3", 32'(acc_cnt[3] - a3), 0);
      wait_drain("p3_drain");

      // Granted requester stalls mid-frame while another waits
      a0 = acc_cnt[0];
      add_byte(0, 8'hC1, 1'b0);
      add_byte(0, 8'hC2, 1'b0);
      add_byte(0, 8'hC3, 1'b1);
      add_byte(2, 8'hD2, 1'b1);
      schedule();
      n = 0;
      while (acc_cnt[0] == a0 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("p4_first_acc", 32'(acc_cnt[0] - a0), 1);
      stall[0] = 1;
      repeat (5) @(negedge clk);
      s  = strobe_cnt;
      a2 = acc_cnt[2];
      repeat (100) @(negedge clk);
      chk("stall_no_strobe", 32'(strobe_cnt), 32'(s));
      chk("stall_grant", 32'(bus.grant), 1);
      chk("stall_busy", 32'(bus.busy), 1);
      chk("stall_no_acc2", 32'(acc_cnt[2]), 32'(a2));
      stall[0] = 0;
      wait_drain("p4_drain");

      // Random frame mixes loaded together
      for (int round = 0; round < 4; round++) begin
         for (int r = 0; r < N; r++) begin
            nf = int'($urandom_range(0, 2));
            for (int f = 0; f < nf; f++) begin
               len = int'($urandom_range(1, 4));
               for (int b = 0; b < len; b++) begin
                  add_byte(r, 8'($urandom_range(0, 255)), b == len - 1);
               end
            end
         end
         schedule();
         wait_drain("rand_drain");
      end

      // Reset while waiting on the UART
      add_byte(1, 8'h71, 1'b0);
      add_byte(1, 8'h72, 1'b1);
      schedule();
      s = strobe_cnt;
      wait_strobe(s, "p5_strobe");
      repeat (3) @(negedge clk);
      chk("p5_pre_busy", 32'(bus.busy), 1);
      #2;
      rst = 1'b0;
      #1;
      chk("p5_busy", 32'(bus.busy), 0);
      chk("p5_grant", 32'(bus.grant), 0);
      chk("p5_tx_vld", 32'(bus.tx_data_vld), 0);
      chk("p5_tx_data", 32'(bus.tx_data), 0);
      exp_q.delete();
      for (int r = 0; r < N; r++) begin
         src_rd[r]   = src_wr[r];
         sched_rd[r] = src_wr[r];
         acc_flag[r] = 0;
      end
      model_last = N - 1;
      for (int r = 0; r < N; r++) add_byte(r, 8'hE0 + 8'(r), 1'b1);
      schedule();
      repeat (3) @(negedge clk);
      rst = 1'b1;
      n = 0;
      while (bus.grant == '0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("p5_first_win", 32'(bus.grant), 1);
      wait_drain("p5_drain");

      // Single-byte frame from requester 2
      add_byte(2, 8'h55, 1'b1);
      schedule();
      wait_drain("p6_drain");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_tx_arb.md
Name: uart_tx_arb

Overview:
- Round-robin arbiter and sequencer that shares one UART transmitter between NUM_REQ byte-stream requesters.
- Each requester sends frames: a sequence of bytes whose final byte is flagged "last".
- The grant is locked for a whole frame, so frames from different requesters never interleave on the serial line.
- Sits between on-chip message sources (status reporters, debug printers) and the UART transmitter's tx_data / tx_data_vld / ready interface.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- HDR_TAG, 4'hA, upper nibble of the frame header byte. Used only when UART_ARB_HDR_EN is defined.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low.
- req_data  in  NUM_REQ*8  byte from each requester; requester i uses bits [8i+7:8i].
- req_vld  in  NUM_REQ  requester i has a byte valid.
- req_last  in  NUM_REQ  the byte on requester i is the last byte of its frame.
- req_ready  out  NUM_REQ  accept strobe; a byte transfers when req_vld[i] and req_ready[i] are both high.
- grant  out  NUM_REQ  one-hot owner of the UART; all zero when idle.
- busy  out  1  high whenever the state is not IDLE.
- tx_data  out  8  byte to the UART transmitter.
- tx_data_vld  out  1  single-cycle start strobe to the UART transmitter.
- uart_ready  in  1  transmitter idle; goes low the cycle after it samples tx_data_vld.

Behaviour:
- Clock and reset: one clock (clk). Reset rst is asynchronous and active-low.
- Reset values:
  - grant=0, busy=0, tx_data=8'h00, tx_data_vld=0, state=IDLE.
  - Internal last_grant pointer = NUM_REQ-1, so requester 0 has first priority.
  - req_ready is combinational and therefore 0 in reset.
- States: IDLE, LOAD, WAIT (plus HDR when the optional feature is compiled in).
- IDLE:
  - If any req_vld is high, pick the first requester with req_vld set, searching upward from last_grant+1 with wrap at NUM_REQ.
  - Register the choice in grant and go to LOAD next cycle.
  - Arbitration costs 1 cycle.
- LOAD:
  - req_ready[g] = uart_ready, where g is the granted index; all other req_ready bits are 0.
  - On a transfer: register tx_data<=req_data[g], tx_data_vld<=1 for exactly one cycle, capture last_r<=req_last[g], go to WAIT.
  - Latency is 1 cycle from the accepting edge to tx_data_vld.
- WAIT:
  - Exit when uart_ready==1 && tx_data_vld==0. This masks the strobe cycle, in which uart_ready is still high.
  - If last_r: clear grant, set last_grant<=g, go to IDLE.
  - Otherwise go to LOAD.
- tx_data holds its value until the next accepted byte.
- Frame lock: req_vld from non-granted requesters is ignored until the granted frame's last byte has been handed to the UART and the UART has returned ready.
- Stall: if the granted requester drops req_vld mid-frame, the grant is held indefinitely; there is no timeout and no byte is issued.
- A 1-byte frame (last on the first byte) is legal.
- When the same requester asks again right after its own frame, it is served only if no other req_vld is high at the IDLE cycle.
- The gap between bytes is the UART byte time plus 2 cycles (WAIT exit, LOAD accept).
- Reset mid-operation: the block returns immediately to reset values and the in-flight frame is abandoned. The UART transmitter shares rst, so there are no partial-byte hazards.

Optional Feature:
- Macro: UART_ARB_HDR_EN.
- Defined:
  - After arbitration, the state goes IDLE->HDR instead of IDLE->LOAD.
  - HDR issues the header byte {HDR_TAG, 4'(g)} with a one-cycle tx_data_vld when uart_ready is high. req_ready stays 0 during HDR.
  - HDR then goes to WAIT with last_r=0, so the frame continues in LOAD.
- Not defined: no HDR state, and the HDR_TAG parameter is unused.

Decomposition:
- Package uart_arb_pkg holds:
  - the state encoding (one-hot localparams IDLE/LOAD/WAIT/HDR);
  - MAX_REQ=8;
  - the header byte width constants.
- Sub-module rr_pick: combinational rotate-priority search. Inputs are the req_vld vector and the last_grant index; outputs are a one-hot grant_next and an any-valid flag. It is instantiated once.

Test Plan:
The bench uses a behavioural UART model with a short bit time (e.g. 10 clk/bit) that drives uart_ready low the cycle after it samples the strobe.
1. Requester 0 sends a 3-byte frame 0x11, 0x22, 0x33 (last on 0x33).
   - Required: tx_data_vld pulses three times carrying 0x11, 0x22, 0x33, each pulse only after uart_ready has returned high.
   - req_ready[0] pulses three times; grant=4'b0001 throughout the frame, then 0.
2. req_vld[0] and req_vld[2] both high at reset release with 1-byte frames 0xA0 and 0xA2; repeat the same pair.
   - Required serial order: 0xA0, 0xA2, 0xA0, 0xA2.
3. Requester 1 sends a 2-byte frame 0x01, 0x02; req_vld[3] rises during byte 1.
   - Required: no req_ready[3] until grant clears; the order is 0x01, 0x02, then requester 3's byte.
4. The granted requester drops req_vld for 100 cycles mid-frame.
   - Required: tx_data_vld stays 0, grant is held, other requesters get no req_ready.
   - On resume, the remaining bytes go out in order.
5. Assert rst during WAIT.
   - Required: busy, grant and tx_data_vld go to 0 asynchronously.
   - After release with all four req_vld high, requester 0 wins.
6. With UART_ARB_HDR_EN defined, requester 2 sends the single byte 0x55 (last).
   - Required: serial bytes 0xA2 then 0x55; req_ready[2] is 0 during the header byte.
